// File: rtl/decode_if.sv
// Signal bundle between the IF/ID register, write-back, M-stage forwarding and
// the Decode stage. The slave side is the decode stage itself.
interface decode_if;
  logic [31:0] D_instr_D;
  logic [31:0] D_PCPlus4_D;
  logic [31:0] D_Result_W;
  logic [4:0]  D_writeReg_W;
  logic        D_regWrite_W;
  logic [31:0] D_ALU_out_M;
  logic        D_forwardA_D;
  logic        D_forwardB_D;

  logic [31:0] D_RD1_D;
  logic [31:0] D_RD2_D;
  logic [31:0] D_signImm_D;
  logic [4:0]  D_Rs_D;
  logic [4:0]  D_Rt_D;
  logic [4:0]  D_Rd_D;
  logic        D_regWrite_D;
  logic        D_memToReg_D;
  logic        D_memWrite_D;
  logic        D_ALUSrc_D;
  logic        D_reg_dest_D;
  logic        D_branch_D;
  logic        D_jump_D;
  logic [2:0]  D_ALU_control_D;
  logic        D_PCSrc_D;
  logic [31:0] D_PCBranch_D;
  logic [31:0] D_PCJump_D;

  modport master (
    output D_instr_D, D_PCPlus4_D, D_Result_W, D_writeReg_W, D_regWrite_W,
           D_ALU_out_M, D_forwardA_D, D_forwardB_D,
    input  D_RD1_D, D_RD2_D, D_signImm_D, D_Rs_D, D_Rt_D, D_Rd_D,
           D_regWrite_D, D_memToReg_D, D_memWrite_D, D_ALUSrc_D, D_reg_dest_D,
           D_branch_D, D_jump_D, D_ALU_control_D, D_PCSrc_D, D_PCBranch_D,
           D_PCJump_D
  );

  modport slave (
    input  D_instr_D, D_PCPlus4_D, D_Result_W, D_writeReg_W, D_regWrite_W,
           D_ALU_out_M, D_forwardA_D, D_forwardB_D,
    output D_RD1_D, D_RD2_D, D_signImm_D, D_Rs_D, D_Rt_D, D_Rd_D,
           D_regWrite_D, D_memToReg_D, D_memWrite_D, D_ALUSrc_D, D_reg_dest_D,
           D_branch_D, D_jump_D, D_ALU_control_D, D_PCSrc_D, D_PCBranch_D,
           D_PCJump_D
  );
endinterface

// File: rtl/decode_stage.sv
// MIPS Instruction Decode stage: register file, main/ALU decoders, sign
// extension, early branch resolution with M-stage forwarding, target adders.
module decode_stage #(
  parameter bit WRITE_BYPASS = 1'b1
) (
  input logic     clk,
  input logic     rst,
  decode_if.slave d
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_e;

  typedef struct packed {
    logic    reg_write;
    logic    reg_dest;
    logic    alu_src;
    logic    branch;
    logic    mem_write;
    logic    mem_to_reg;
    logic    jump;
    alu_op_e alu_op;
  } ctrl_t;

  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [31:0] sign_imm;

  assign op       = d.D_instr_D[31:26];
  assign funct    = d.D_instr_D[5:0];
  assign rs       = d.D_instr_D[25:21];
  assign rt       = d.D_instr_D[20:16];
  assign sign_imm = {{16{d.D_instr_D[15]}}, d.D_instr_D[15:0]};

  // ---------------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------------
  logic [31:0] regs [32];
  logic        wr_active;

  assign wr_active = d.D_regWrite_W && (d.D_writeReg_W != 5'd0);

  // NOTE: the register file is built from flops, not a RAM macro, because reset
  // must clear all 32 entries in a single edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wr_active) begin
      regs[d.D_writeReg_W] <= d.D_Result_W;
    end
  end

  logic [31:0] rd1;
  logic [31:0] rd2;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (!rst) begin
      if (WRITE_BYPASS && wr_active && d.D_writeReg_W == rs) rd1 = d.D_Result_W;
      else if (rs != 5'd0)                                   rd1 = regs[rs];
      if (WRITE_BYPASS && wr_active && d.D_writeReg_W == rt) rd2 = d.D_Result_W;
      else if (rt != 5'd0)                                   rd2 = regs[rt];
    end
  end

  // ---------------------------------------------------------------------------
  // Main decoder and ALU decoder
  // ---------------------------------------------------------------------------
  ctrl_t       ctrl;
  logic [2:0]  alu_control;

  always_comb begin
    ctrl = '0;
    unique case (op)
      OP_RTYPE: ctrl = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ALUOP_FUNCT};
      OP_LW:    ctrl = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, ALUOP_ADD};
      OP_SW:    ctrl = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, ALUOP_ADD};
      OP_BEQ:   ctrl = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ALUOP_SUB};
      OP_ADDI:  ctrl = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ALUOP_ADD};
      OP_J:     ctrl = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ALUOP_ADD};
      default:  ctrl = '0;
    endcase
  end

  always_comb begin
    alu_control = 3'b000;
    case (ctrl.alu_op)
      ALUOP_ADD: alu_control = 3'b010;
      ALUOP_SUB: alu_control = 3'b110;
      ALUOP_FUNCT: begin
        case (funct)
          6'b100000: alu_control = 3'b010;
          6'b100010: alu_control = 3'b110;
          6'b100100: alu_control = 3'b000;
          6'b100101: alu_control = 3'b001;
          6'b101010: alu_control = 3'b111;
          default:   alu_control = 3'b000;
        endcase
      end
      default: alu_control = 3'b000;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Branch resolution in Decode, operands optionally forwarded from M
  // ---------------------------------------------------------------------------
  logic [31:0] cmp_a;
  logic [31:0] cmp_b;

  assign cmp_a = d.D_forwardA_D ? d.D_ALU_out_M : rd1;
  assign cmp_b = d.D_forwardB_D ? d.D_ALU_out_M : rd2;

  assign d.D_RD1_D         = rd1;
  assign d.D_RD2_D         = rd2;
  assign d.D_signImm_D     = sign_imm;
  assign d.D_Rs_D          = rs;
  assign d.D_Rt_D          = rt;
  assign d.D_Rd_D          = d.D_instr_D[15:11];
  assign d.D_regWrite_D    = ctrl.reg_write;
  assign d.D_memToReg_D    = ctrl.mem_to_reg;
  assign d.D_memWrite_D    = ctrl.mem_write;
  assign d.D_ALUSrc_D      = ctrl.alu_src;
  assign d.D_reg_dest_D    = ctrl.reg_dest;
  assign d.D_branch_D      = ctrl.branch;
  assign d.D_jump_D        = ctrl.jump;
  assign d.D_ALU_control_D = alu_control;
  assign d.D_PCSrc_D       = !rst && ctrl.branch && (cmp_a == cmp_b);
  assign d.D_PCBranch_D    = d.D_PCPlus4_D + {sign_imm[29:0], 2'b00};
  assign d.D_PCJump_D      = {d.D_PCPlus4_D[31:28], d.D_instr_D[25:0], 2'b00};

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: both bypass variants run in lockstep against a
// behavioural model, plus directed literal checks.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr = '0;
  logic [31:0] pc4 = '0;
  logic [31:0] res = '0;
  logic [4:0]  wr = '0;
  logic        we = 1'b0;
  logic [31:0] alu_m = '0;
  logic        fa = 1'b0;
  logic        fb = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  decode_if if1 ();
  decode_if if0 ();

  assign if1.D_instr_D = instr;   assign if0.D_instr_D = instr;
  assign if1.D_PCPlus4_D = pc4;   assign if0.D_PCPlus4_D = pc4;
  assign if1.D_Result_W = res;    assign if0.D_Result_W = res;
  assign if1.D_writeReg_W = wr;   assign if0.D_writeReg_W = wr;
  assign if1.D_regWrite_W = we;   assign if0.D_regWrite_W = we;
  assign if1.D_ALU_out_M = alu_m; assign if0.D_ALU_out_M = alu_m;
  assign if1.D_forwardA_D = fa;   assign if0.D_forwardA_D = fa;
  assign if1.D_forwardB_D = fb;   assign if0.D_forwardB_D = fb;

  decode_stage #(.WRITE_BYPASS(1'b1)) dut_byp (.clk(clk), .rst(rst), .d(if1));
  decode_stage #(.WRITE_BYPASS(1'b0)) dut_nob (.clk(clk), .rst(rst), .d(if0));

  typedef struct packed {
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] sign_imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        reg_write;
    logic        reg_dest;
    logic        alu_src;
    logic        branch;
    logic        mem_write;
    logic        mem_to_reg;
    logic        jump;
    logic [2:0]  alu_control;
    logic        pc_src;
    logic [31:0] pc_branch;
    logic [31:0] pc_jump;
  } out_t;

  out_t o1, o0;
  assign o1 = {if1.D_RD1_D, if1.D_RD2_D, if1.D_signImm_D, if1.D_Rs_D, if1.D_Rt_D,
               if1.D_Rd_D, if1.D_regWrite_D, if1.D_reg_dest_D, if1.D_ALUSrc_D,
               if1.D_branch_D, if1.D_memWrite_D, if1.D_memToReg_D, if1.D_jump_D,
               if1.D_ALU_control_D, if1.D_PCSrc_D, if1.D_PCBranch_D, if1.D_PCJump_D};
  assign o0 = {if0.D_RD1_D, if0.D_RD2_D, if0.D_signImm_D, if0.D_Rs_D, if0.D_Rt_D,
               if0.D_Rd_D, if0.D_regWrite_D, if0.D_reg_dest_D, if0.D_ALUSrc_D,
               if0.D_branch_D, if0.D_memWrite_D, if0.D_memToReg_D, if0.D_jump_D,
               if0.D_ALU_control_D, if0.D_PCSrc_D, if0.D_PCBranch_D, if0.D_PCJump_D};

  // Architectural register contents as the program sees them.
  logic [31:0] mregs [32];
  initial for (int i = 0; i < 32; i++) mregs[i] = '0;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) mregs[i] <= '0;
    end else if (we && wr != 5'd0) begin
      mregs[wr] <= res;
    end
  end

  function automatic logic [31:0] model_read(input logic [4:0] addr, input bit bypass);
    if (rst) return '0;
    if (bypass && we && wr != 5'd0 && wr == addr) return res;
    return mregs[addr];
  endfunction

  function automatic out_t model_out(input bit bypass);
    out_t o;
    logic [5:0] op;
    logic [5:0] funct;
    int alu_op;
    logic [31:0] a, b;
    op = instr[31:26];
    funct = instr[5:0];
    o = '0;
    o.rs = instr[25:21];
    o.rt = instr[20:16];
    o.rd = instr[15:11];
    o.rd1 = model_read(instr[25:21], bypass);
    o.rd2 = model_read(instr[20:16], bypass);
    o.sign_imm = {{16{instr[15]}}, instr[15:0]};
    alu_op = 0;
    case (op)
      6'b000000: begin o.reg_write = 1; o.reg_dest = 1; alu_op = 2; end
      6'b100011: begin o.reg_write = 1; o.alu_src = 1; o.mem_to_reg = 1; end
      6'b101011: begin o.alu_src = 1; o.mem_write = 1; end
      6'b000100: begin o.branch = 1; alu_op = 1; end
      6'b001000: begin o.reg_write = 1; o.alu_src = 1; end
      6'b000010: o.jump = 1;
      default: ;
    endcase
    if (alu_op == 0)      o.alu_control = 3'b010;
    else if (alu_op == 1) o.alu_control = 3'b110;
    else begin
      case (funct)
        6'b100000: o.alu_control = 3'b010;
        6'b100010: o.alu_control = 3'b110;
        6'b100101: o.alu_control = 3'b001;
        6'b101010: o.alu_control = 3'b111;
        default:   o.alu_control = 3'b000;
      endcase
    end
    a = fa ? alu_m : o.rd1;
    b = fb ? alu_m : o.rd2;
    o.pc_src = !rst && o.branch && (a == b);
    o.pc_branch = pc4 + o.sign_imm * 32'd4;
    o.pc_jump = {pc4[31:28], instr[25:0], 2'b00};
    return o;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input out_t act, input out_t exp);
    check({tag, ".rd1"}, act.rd1, exp.rd1);
    check({tag, ".rd2"}, act.rd2, exp.rd2);
    check({tag, ".sign_imm"}, act.sign_imm, exp.sign_imm);
    check({tag, ".rs"}, 32'(act.rs), 32'(exp.rs));
    check({tag, ".rt"}, 32'(act.rt), 32'(exp.rt));
    check({tag, ".rd"}, 32'(act.rd), 32'(exp.rd));
    check({tag, ".ctrl"},
          32'({act.reg_write, act.reg_dest, act.alu_src, act.branch, act.mem_write, act.mem_to_reg, act.jump}),
          32'({exp.reg_write, exp.reg_dest, exp.alu_src, exp.branch, exp.mem_write, exp.mem_to_reg, exp.jump}));
    check({tag, ".alu_control"}, 32'(act.alu_control), 32'(exp.alu_control));
    check({tag, ".pc_src"}, 32'(act.pc_src), 32'(exp.pc_src));
    check({tag, ".pc_branch"}, act.pc_branch, exp.pc_branch);
    check({tag, ".pc_jump"}, act.pc_jump, exp.pc_jump);
  endtask

  // Outputs are combinational; compare both variants once per cycle.
  always @(negedge clk) begin
    check_out("byp", o1, model_out(1'b1));
    check_out("nob", o0, model_out(1'b0));
  end

  task automatic apply(input logic r, input logic [31:0] i, input logic [31:0] p,
                       input logic w_en, input logic [4:0] w_addr, input logic [31:0] w_data,
                       input logic [31:0] m, input logic f_a, input logic f_b);
    @(posedge clk);
    #1;
    rst = r; instr = i; pc4 = p; we = w_en; wr = w_addr; res = w_data;
    alu_m = m; fa = f_a; fb = f_b;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  initial begin
    logic [5:0] ops [7];
    logic [5:0] functs [6];
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010, 6'b111111};
    functs = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000111};

    apply(1, 0, 0, 0, 0, 0, 0, 0, 0);
    settle();
    check("rst_rd1", if1.D_RD1_D, 32'h0);

    // Reset clears a written register; reset beats a simultaneous write.
    apply(0, 0, 0, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0);
    apply(1, 0, 0, 0, 0, 0, 0, 0, 0);
    apply(0, 32'(5) << 21, 0, 0, 0, 0, 0, 0, 0);
    settle();
    check("rst_clears_r5", if1.D_RD1_D, 32'h0);
    apply(1, 0, 0, 1, 5'd7, 32'h77777777, 0, 0, 0);
    apply(0, 32'(7) << 21, 0, 0, 0, 0, 0, 0, 0);
    settle();
    check("rst_beats_write_r7", if1.D_RD1_D, 32'h0);

    // Normal write/read and r0 immutability.
    apply(0, 0, 0, 1, 5'd8, 32'h12345678, 0, 0, 0);
    apply(0, 0, 0, 1, 5'd0, 32'hFFFFFFFF, 0, 0, 0);
    apply(0, 32'(8) << 21, 0, 0, 0, 0, 0, 0, 0);
    settle();
    check("read_r8", if1.D_RD1_D, 32'h12345678);
    check("read_r0", if1.D_RD2_D, 32'h0);

    // Write-through versus next-cycle visibility.
    apply(0, 0, 0, 1, 5'd9, 32'h11111111, 0, 0, 0);
    apply(0, 32'(9) << 21, 0, 1, 5'd9, 32'hA5A5A5A5, 0, 0, 0);
    settle();
    check("bypass_on", if1.D_RD1_D, 32'hA5A5A5A5);
    check("bypass_off_old", if0.D_RD1_D, 32'h11111111);
    apply(0, 32'(9) << 21, 0, 0, 0, 0, 0, 0, 0);
    settle();
    check("bypass_off_new", if0.D_RD1_D, 32'hA5A5A5A5);

    // Decoder spot checks.
    apply(0, 32'h02328020, 0, 0, 0, 0, 0, 0, 0);
    settle();
    check("add_ctrl", {if1.D_regWrite_D, if1.D_reg_dest_D, if1.D_ALUSrc_D}, 32'b110);
    check("add_aluctl", 32'(if1.D_ALU_control_D), 32'b010);
    apply(0, 32'h8E280004, 0, 0, 0, 0, 0, 0, 0);
    settle();
    check("lw_ctrl", {if1.D_memToReg_D, if1.D_ALUSrc_D}, 32'b11);
    check("lw_imm", if1.D_signImm_D, 32'h4);
    apply(0, 32'hFC000000, 0, 0, 0, 0, 0, 0, 0);
    settle();
    check("undef_ctrl", {if1.D_regWrite_D, if1.D_reg_dest_D, if1.D_ALUSrc_D, if1.D_branch_D,
                         if1.D_memWrite_D, if1.D_memToReg_D, if1.D_jump_D}, 32'h0);

    // Branch with a negative offset, then forwarding breaks the equality.
    apply(0, 0, 0, 1, 5'd1, 32'd3, 0, 0, 0);
    apply(0, 0, 0, 1, 5'd2, 32'd3, 0, 0, 0);
    apply(0, 32'h1022FFFF, 32'h100, 0, 0, 0, 0, 0, 0);
    settle();
    check("beq_taken", 32'(if1.D_PCSrc_D), 32'h1);
    check("beq_target", if1.D_PCBranch_D, 32'h000000FC);
    apply(0, 32'h1022FFFF, 32'h100, 0, 0, 0, 32'd4, 1, 0);
    settle();
    check("beq_fwd_not_taken", 32'(if1.D_PCSrc_D), 32'h0);

    // Jump target keeps the PC+4 region bits.
    apply(0, 32'h08000040, 32'h40000004, 0, 0, 0, 0, 0, 0);
    settle();
    check("j_flag", 32'(if1.D_jump_D), 32'h1);
    check("j_target", if1.D_PCJump_D, 32'h40000100);

    // Randomised traffic; rs==rt and M-value reuse make branches resolve both ways.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] ri;
      logic [4:0]  rs_r, rt_r;
      logic [31:0] m;
      ri = $urandom;
      ri[31:26] = ops[$urandom_range(0, 6)];
      if ($urandom_range(0, 1) == 1) ri[5:0] = functs[$urandom_range(0, 5)];
      rs_r = 5'($urandom_range(0, 31));
      rt_r = ($urandom_range(0, 3) == 0) ? rs_r : 5'($urandom_range(0, 31));
      ri[25:21] = rs_r;
      ri[20:16] = rt_r;
      m = ($urandom_range(0, 1) == 1) ? mregs[rt_r] : $urandom;
      apply(($urandom_range(0, 39) == 0), ri, $urandom,
            ($urandom_range(0, 2) != 0), 5'($urandom_range(0, 31)), $urandom,
            m, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
    end
    settle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
